// File: rtl/one_hot_demux_pkt_pkg.sv
// Shared types and helpers for the one-hot packet demultiplexer.
package one_hot_demux_pkt_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      FWD  = 2'd1,
      DROP = 2'd2
   } state_t;

   // Width of the empty-byte field; never narrower than one bit.
   function automatic int calc_empty_w(input int data_w);
      int w;
      w = $clog2(data_w / 8);
      return (w < 1) ? 1 : w;
   endfunction

endpackage

// File: rtl/one_hot_demux_pkt_one_hot_chk.sv
// Combinational check that a vector has exactly one bit set.
module one_hot_chk #(
   parameter int W = 2
) (
   input  logic [W-1:0] vec,
   output logic         is_one_hot
);

   assign is_one_hot = (vec != '0) && ((vec & (vec - 1'b1)) == '0);

endmodule

// File: rtl/one_hot_demux_pkt.sv
// Packet-stream demux: one ST input steered to one of OUTPUT_CNT outputs by a one-hot select.
// Optional drop counter enabled by ONE_HOT_DEMUX_PKT_DROP_CNT_EN.
module one_hot_demux_pkt
   import one_hot_demux_pkt_pkg::*;
#(
   parameter  int OUTPUT_CNT = 2,
   parameter  int DATA_W     = 32,
   localparam int EMPTY_W    = calc_empty_w(DATA_W)
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic [OUTPUT_CNT-1:0] sel_one_hot_i,
   input  logic [DATA_W-1:0]     in_data_i,
   input  logic                  in_sop_i,
   input  logic                  in_eop_i,
   input  logic [EMPTY_W-1:0]    in_empty_i,
   input  logic                  in_valid_i,
   output logic                  in_ready_o,
   output logic [DATA_W-1:0]     out_data_o,
   output logic                  out_sop_o,
   output logic                  out_eop_o,
   output logic [EMPTY_W-1:0]    out_empty_o,
   output logic [OUTPUT_CNT-1:0] out_valid_o,
   input  logic [OUTPUT_CNT-1:0] out_ready_i,
   output logic                  sel_err_o,
`ifdef ONE_HOT_DEMUX_PKT_DROP_CNT_EN
   output logic [31:0]           drop_cnt_o,
`endif
   output logic                  pkt_err_o
);

   state_t                  state;
   logic [OUTPUT_CNT-1:0]   dest_q;
   logic [OUTPUT_CNT-1:0]   fwd_dest;
   logic                    sel_ok;
   logic                    reg_full;
   logic                    drain;
   logic                    drop_ok;
   logic                    accept;
   logic                    fwd_beat;
   logic                    drop_pkt;

   one_hot_chk #(.W(OUTPUT_CNT)) u_sel_chk (
      .vec        (sel_one_hot_i),
      .is_one_hot (sel_ok)
   );

   assign reg_full = |out_valid_o;
   // The held beat's own valid bit names its port, so only that ready can drain it.
   assign drain    = |(out_valid_o & out_ready_i);
   // A DROP-state SOP that starts a good packet needs register room like any forwarded beat.
   assign drop_ok  = (state == DROP) && !(in_sop_i && sel_ok);
   assign in_ready_o = drop_ok || !reg_full || drain;

   assign accept   = in_valid_i && in_ready_o;
   assign fwd_beat = accept && (in_sop_i ? sel_ok : (state == FWD));
   assign drop_pkt = accept && in_sop_i && !sel_ok;
   assign fwd_dest = in_sop_i ? sel_one_hot_i : dest_q;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state       <= IDLE;
         dest_q      <= '0;
         out_valid_o <= '0;
         out_data_o  <= '0;
         out_sop_o   <= 1'b0;
         out_eop_o   <= 1'b0;
         out_empty_o <= '0;
         sel_err_o   <= 1'b0;
         pkt_err_o   <= 1'b0;
      end else begin
         sel_err_o <= 1'b0;
         pkt_err_o <= 1'b0;

         if (fwd_beat) begin
            out_valid_o <= fwd_dest;
            out_data_o  <= in_data_i;
            out_sop_o   <= in_sop_i;
            out_eop_o   <= in_eop_i;
            out_empty_o <= in_empty_i;
         end else if (drain) begin
            out_valid_o <= '0;
         end

         if (accept) begin
            if (in_sop_i) begin
               // A SOP outside IDLE leaves the previous packet unterminated.
               if (state != IDLE) pkt_err_o <= 1'b1;
               if (sel_ok) begin
                  dest_q <= sel_one_hot_i;
                  state  <= in_eop_i ? IDLE : FWD;
               end else begin
                  sel_err_o <= 1'b1;
                  state     <= in_eop_i ? IDLE : DROP;
               end
            end else if (state == IDLE) begin
               pkt_err_o <= 1'b1;
            end else if (in_eop_i) begin
               state <= IDLE;
            end
         end
      end
   end

`ifdef ONE_HOT_DEMUX_PKT_DROP_CNT_EN
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i)
         drop_cnt_o <= '0;
      else if (drop_pkt && (drop_cnt_o != 32'hFFFF_FFFF))
         drop_cnt_o <= drop_cnt_o + 32'd1;
   end
`else
   logic unused_drop;
   assign unused_drop = drop_pkt;
`endif

endmodule
